// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu -- load/store request unit between EX and the data cache.
//
// Accepts one memory operation per instruction from EX, runs a single
// outstanding request/response handshake with the data cache and holds EX
// (lsu_ready_go low) until the access completes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ex_valid            EX holds a valid instruction
//   ex_memread/memwrite load / store (both set => store)
//   ex_memop            [1:0] access size, [2] zero-extend (used downstream)
//   ex_addr, ex_wdata   effective address, unshifted store data
//   mem_allowin         MEM accepts EX's instruction this cycle
//   lsu_ready_go        EX may hand its instruction to MEM
//   lsu_busy            FSM not idle
//   lsu_misalign        one-cycle pulse on a rejected misaligned access
//   dcache_req_*        registered request: valid/ready/we/addr/wdata/wmask
//   dcache_resp_*       response valid and doubleword-aligned read data
//   lsu_rdata           last load's aligned doubleword
module ysyx_22050243_lsu #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [2:0]        ex_memop,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [63:0]       ex_wdata,
  input  logic              mem_allowin,
  output logic              lsu_ready_go,
  output logic              lsu_busy,
  output logic              lsu_misalign,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic              dcache_req_we,
  output logic [ADDR_W-1:0] dcache_req_addr,
  output logic [63:0]       dcache_req_wdata,
  output logic [7:0]        dcache_req_wmask,
  input  logic              dcache_resp_valid,
  input  logic [63:0]       dcache_resp_rdata,
  output logic [63:0]       lsu_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        mask_q, mask_d;
  logic [63:0]       rdata_q, rdata_d;

  logic       is_mem;
  logic       misaligned;
  logic [2:0] ofs;
  logic [7:0] size_mask;
  logic [7:0] shifted_mask;
  logic       memop_unused;

  // Bit 2 selects zero-extension, which the memory stage applies.
  assign memop_unused = ex_memop[2];

  assign is_mem = ex_valid & (ex_memread | ex_memwrite);
  assign ofs    = ex_addr[2:0];

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (ex_memop[1:0])
      2'b00: begin
        misaligned = 1'b0;
        size_mask  = 8'h01;
      end
      2'b01: begin
        misaligned = ofs[0];
        size_mask  = 8'h03;
      end
      2'b10: begin
        misaligned = |ofs[1:0];
        size_mask  = 8'h0F;
      end
      default: begin
        misaligned = |ofs;
        size_mask  = 8'hFF;
      end
    endcase
  end

  // 8-bit result truncates any lanes shifted past the doubleword.
  assign shifted_mask = size_mask << ofs;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (is_mem && !misaligned) begin
          we_d    = ex_memwrite;
          addr_d  = {ex_addr[ADDR_W-1:3], 3'b000};
          mask_d  = ex_memwrite ? shifted_mask : '0;
          wdata_d = ex_memwrite ? (ex_wdata << {ofs, 3'b000}) : '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dcache_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (dcache_resp_valid) begin
          if (!we_q) rdata_d = dcache_resp_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        if (mem_allowin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    lsu_ready_go = 1'b0;
    lsu_misalign = 1'b0;
    case (state_q)
      IDLE: begin
        lsu_ready_go = !is_mem || misaligned;
        lsu_misalign = is_mem && misaligned;
      end
      DONE:    lsu_ready_go = 1'b1;
      default: lsu_ready_go = 1'b0;
    endcase
  end

  assign lsu_busy         = (state_q != IDLE);
  assign dcache_req_valid = (state_q == REQ);
  assign dcache_req_we    = we_q;
  assign dcache_req_addr  = addr_q;
  assign dcache_req_wdata = wdata_q;
  assign dcache_req_wmask = mask_q;
  assign lsu_rdata        = rdata_q;

endmodule

// File: doc/ysyx_22050243_lsu.md
# ysyx_22050243_lsu

Load/store request unit between the execute stage and the data cache; it sits directly upstream of the memory stage. It takes one memory operation per instruction from EX and performs the cache request/response handshake. It holds EX (`lsu_ready_go` low) until the access completes. It produces the byte-lane write mask, the lane-shifted store data, and the doubleword-aligned load data that the memory stage extracts and sign-extends.

## Interface
Parameters
- `ADDR_W`, default 64: address width; request address is always 8-byte aligned.

Ports
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  EX holds a valid instruction this cycle.
- `ex_memread`  in  1  instruction is a load.
- `ex_memwrite`  in  1  instruction is a store.
- `ex_memop`  in  3  load encoding: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Store size is `[1:0]`: 00 sb, 01 sh, 10 sw, 11 sd.
- `ex_addr`  in  ADDR_W  effective address (ALU result).
- `ex_wdata`  in  64  unshifted store data (rs2).
- `mem_allowin`  in  1  memory stage accepts EX's instruction this cycle.
- `lsu_ready_go`  out  1  EX may hand its instruction to MEM.
- `lsu_busy`  out  1  FSM not in IDLE.
- `lsu_misalign`  out  1  one-cycle pulse: misaligned access rejected.
- `dcache_req_valid`  out  1  request valid.
- `dcache_req_ready`  in  1  cache accepts request.
- `dcache_req_we`  out  1  1 = write.
- `dcache_req_addr`  out  ADDR_W  `{addr[ADDR_W-1:3],3'b0}`.
- `dcache_req_wdata`  out  64  store data shifted left by `addr[2:0]*8`.
- `dcache_req_wmask`  out  8  byte-enable mask.
- `dcache_resp_valid`  in  1  response (read data or write ack).
- `dcache_resp_rdata`  in  64  doubleword-aligned read data.
- `lsu_rdata`  out  64  last load's aligned doubleword; drives the memory stage's aligned-data input.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - No memory operation (`!ex_valid`, or neither read nor write): `lsu_ready_go = 1`, no request issued.
  - Memory op, aligned: capture we, aligned address, mask and shifted data into request registers, then go to REQ. `lsu_ready_go = 0`.
  - Memory op, misaligned: `lsu_misalign = 1` for this cycle, `lsu_ready_go = 1`, no request issued, stay in IDLE.
  - Misaligned means: size h with `addr[0] != 0`; size w with `addr[1:0] != 0`; size d with `addr[2:0] != 0`.
  - If both `ex_memread` and `ex_memwrite` are set, the access is treated as a write.
- **REQ**
  - `dcache_req_valid = 1`. The request fields come only from the registers and stay stable until accepted.
  - When `dcache_req_ready` is high, go to WAIT.
- **WAIT**
  - When `dcache_resp_valid` is high: if the access is a read, latch `dcache_resp_rdata` into `lsu_rdata`; then go to DONE.
  - For a write, `lsu_rdata` is unchanged.
- **DONE**
  - `lsu_ready_go = 1`.
  - If `mem_allowin` is high, go to IDLE. Otherwise hold in DONE with all registers stable.
- Write mask for byte offset `a = addr[2:0]`: sb `8'h01<<a`, sh `8'h03<<a`, sw `8'h0F<<a`, sd `8'hFF`. Mask shifts are truncated to 8 bits.
- Request wdata and wmask are only meaningful when `dcache_req_we = 1`. For reads, the mask is driven as 0.
- Exactly one outstanding request at a time. `dcache_resp_valid` seen outside WAIT is ignored.
- Reset values: FSM = IDLE; all request registers 0; `lsu_rdata` = 0; every output 0 except `lsu_ready_go`, which evaluates per IDLE rules.

## Timing
- `lsu_ready_go`, `lsu_misalign` and `lsu_busy` are combinational from state and EX inputs. All other outputs are registered or decoded from state.
- Minimum load/store latency, with ready and response each arriving in the first cycle allowed:
  - C0: IDLE captures the operation.
  - C1: REQ, accepted.
  - C2: WAIT, response arrives.
  - C3: DONE, `lsu_ready_go = 1`.
- `lsu_rdata` is valid from C3. It holds until the next read response, so it is stable through the cycle after EX→MEM transfer.
- Each cycle of `dcache_req_ready` low, and each cycle of response delay, adds one cycle.
- Asserting `rst` in any state forces IDLE and clears `dcache_req_valid` immediately (asynchronously). No partial request survives; the cache is reset on the same signal.

## Test plan
- **Aligned store:** sd addr `0x80000010`, data `0x1122334455667788`, ready/resp immediate.
  - Required: req addr `0x80000010`, wmask `0xFF`, we = 1; `lsu_ready_go` high exactly at C3.
- **Byte store shift:** sb addr `0x80000005`, data `0xAB`.
  - Required: wdata `0x0000AB0000000000`, wmask `0x20`, req addr `0x80000000`.
- **Load and hold:** lbu addr `0x80000003`, resp rdata `0xDEADBEEFCAFEF00D`.
  - Required: wmask 0, we = 0; `lsu_rdata = 0xDEADBEEFCAFEF00D` from DONE.
  - Then a following sw: `lsu_rdata` unchanged.
- **Misaligned access:** lw addr `0x80000002`.
  - Required: `lsu_misalign` pulses 1 cycle, no `dcache_req_valid`, `lsu_ready_go = 1`, FSM stays IDLE.
- **Backpressure:** `dcache_req_ready` low 3 cycles, then `mem_allowin` low 2 cycles in DONE.
  - Required: request fields stable throughout; DONE held 3 cycles; total 8 cycles from capture to IDLE.
- **Reset mid-access:** `rst` asserted in WAIT.
  - Required: `dcache_req_valid`/`lsu_busy` 0 immediately and `lsu_rdata` = 0; a late `dcache_resp_valid` after reset release is ignored.
